micro_sequencer: RTL and testbench
==================================

# micro_sequencer

- Microprogram sequencer that consumes the 2-bit next-address type produced by the branch-condition logic.
- Each cycle it registers the next control-store address from one of four sources:
  - the current address plus one,
  - the jump field of the microinstruction register,
  - the opcode decode vector,
  - an optional micro-subroutine return stack.
- Sits between the branch-condition logic and the control store of the microprogrammed datapath.
- Also provides stall (memory wait) and halt handling.

## Interface
Parameters:
- MICRO_SEQUENCER_CSADDR = 11: control-store address width.
- MICRO_SEQUENCER_TIPO = 2: width of the next-address type bus.
- MICRO_SEQUENCER_OPFIELD = 8: width of the IR opcode field used for decode (op[1:0], op3[5:0]).
- MICRO_SEQUENCER_STACK_DEPTH = 4: return-stack entries, power of two.

Ports:
- MICRO_SEQUENCER_CLOCK_50  in  1  single clock, rising edge.
- MICRO_SEQUENCER_ResetInLow_In  in  1  reset, asynchronous, active-low.
- MICRO_SEQUENCER_Tipo_InBus  in  2  next-address type from the branch-condition logic.
- MICRO_SEQUENCER_JumpAddr_InBus  in  CSADDR  jump field of the current microinstruction.
- MICRO_SEQUENCER_OpField_InBus  in  OPFIELD  opcode field of the IR.
- MICRO_SEQUENCER_Call_In  in  1  current microinstruction is a call; qualifies a jump.
- MICRO_SEQUENCER_Wait_In  in  1  memory not ready; stall.
- MICRO_SEQUENCER_Halt_In  in  1  halt request.
- MICRO_SEQUENCER_CsAddr_OutBus  out  CSADDR  registered control-store address.
- MICRO_SEQUENCER_Stalled_Out  out  1  high while in WAIT.
- MICRO_SEQUENCER_Halted_Out  out  1  high while in HALT.
- MICRO_SEQUENCER_Error_Out  out  1  sticky: address wrap or stack misuse.

## Operation
FSM states: BOOT, RUN, WAIT, HALT.
- BOOT
  - Entered on reset; address is held at 0.
  - Always moves to RUN after one clock; the address stays 0 in that cycle.
- RUN: on each edge, the priority is Halt_In > Wait_In > Tipo.
  - Halt_In=1: go to HALT; the address holds.
  - Wait_In=1: go to WAIT; the address holds.
  - Otherwise the address updates by Tipo:
    - 00 next: address+1.
    - 01 jump: JumpAddr.
    - 10 decode: {1'b1, OpField, 2'b00}, truncated or padded to CSADDR. The default width gives exactly 11 bits.
    - 11 return (only when the macro is enabled): pop the stack.
- WAIT
  - The address holds.
  - Halt_In=1: go to HALT.
  - Wait_In=0: back to RUN. The Tipo present on that edge is applied at the same edge, so no extra bubble is added.
- HALT
  - Absorbing; the address holds. Only reset leaves HALT.
- Wrap: next from address 2^CSADDR-1 gives address 0, and Error is set.
- Error clears only on reset.
- Reset asserted mid-operation asynchronously forces:
  - state BOOT, address 0, Error 0, stack empty.
  - All flags go to 0.

## Timing
- Reset values:
  - CsAddr=0, Stalled=0, Halted=0, Error=0.
- All outputs are registered.
- Latency: Tipo/JumpAddr/OpField sampled at edge N appear on CsAddr after edge N; one cycle per microinstruction.
- Stalled and Halted are asserted in the cycle after the edge that enters the state.
- Error is asserted in the cycle after the offending edge.

## Configuration
MICRO_SEQUENCER_CALL_STACK_EN selects the return-stack behaviour.
- Defined: Tipo=01 with Call_In=1 pushes address+1, then jumps.
  - Tipo=11 pops into the address.
  - Push when full: the push is dropped, the jump still happens, and Error is set.
  - Pop when empty: address becomes 0 and Error is set.
- Not defined: no stack storage is built.
  - Call_In is ignored.
  - Tipo=11 behaves as next (address+1).
  - Error reflects wrap only.

## Structure
- Shared package:
  - Tipo encodings (NEXT=2'b00, JUMP=2'b01, DECODE=2'b10, RETURN=2'b11).
  - FSM state encoding.
  - Decode-address prefix/suffix constants.
- Sub-module: micro_return_stack (push/pop/full/empty, depth parameter). It is instantiated only under the macro.

## Test plan
- Reset release, Tipo=00 held for 3 cycles → CsAddr sequence 0 (BOOT), 0, 1, 2, 3; Error=0.
- Tipo=10 with OpField=8'b10_000000 → CsAddr=11'b1_10000000_00=0x600 next cycle. Then Tipo=01 with JumpAddr=0x123 → 0x123.
- Wait_In=1 for 2 cycles at CsAddr=5 with Tipo=00:
  - CsAddr holds at 5 and Stalled=1 for 2 cycles.
  - On release CsAddr=6 and Stalled=0.
- Jump to 0x7FF, then Tipo=00 → CsAddr=0 and Error=1. Error stays 1 until ResetInLow=0, which forces CsAddr=0 and Error=0 without waiting for a clock.
- Halt_In=1 and Wait_In=1 on the same edge → HALT with Halted=1, Stalled=0. CsAddr stays frozen for 10 cycles regardless of Tipo.
- With MICRO_SEQUENCER_CALL_STACK_EN, return stack:
  - Call at 0x010 to 0x200, then Tipo=11 → CsAddr 0x200, then 0x011.
  - 5 nested calls → Error=1; the 5th return address is dropped.
  - Pop when empty → CsAddr=0 and Error=1.

Source files
------------

// File: rtl/micro_sequencer_pkg.sv
// micro_sequencer_pkg: next-address type encodings, FSM states and decode-address framing
package micro_sequencer_pkg;
  typedef enum logic [1:0] {
    TIPO_NEXT   = 2'b00,
    TIPO_JUMP   = 2'b01,
    TIPO_DECODE = 2'b10,
    TIPO_RETURN = 2'b11
  } tipo_e;
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_WAIT, S_HALT} state_e;
  localparam logic DECODE_PREFIX = 1'b1;
  localparam logic [1:0] DECODE_SUFFIX = 2'b00;
endpackage

// File: rtl/micro_return_stack.sv
// micro_return_stack: LIFO of micro-subroutine return addresses; full push and empty pop are no-ops
module micro_return_stack #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] pushData,
  output logic [WIDTH-1:0] topData,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0] count;
  logic [PW-1:0] topIdx;
  assign full = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
  assign topIdx = PW'(count - 1'b1);
  assign topData = mem[topIdx];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (push && !full) count <= count + 1'b1;
    else if (pop && !empty) count <= count - 1'b1;
  always_ff @(posedge clk)
    if (push && !full) mem[count[PW-1:0]] <= pushData;
endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: control-store next-address sequencer with stall/halt FSM
// Return stack (call/return) is built only when MICRO_SEQUENCER_CALL_STACK_EN is defined.
module micro_sequencer
  import micro_sequencer_pkg::*;
#(
  parameter int MICRO_SEQUENCER_CSADDR      = 11,
  parameter int MICRO_SEQUENCER_TIPO        = 2,
  parameter int MICRO_SEQUENCER_OPFIELD     = 8,
  parameter int MICRO_SEQUENCER_STACK_DEPTH = 4
) (
  input  logic                               MICRO_SEQUENCER_CLOCK_50,
  input  logic                               MICRO_SEQUENCER_ResetInLow_In,
  input  logic [MICRO_SEQUENCER_TIPO-1:0]    MICRO_SEQUENCER_Tipo_InBus,
  input  logic [MICRO_SEQUENCER_CSADDR-1:0]  MICRO_SEQUENCER_JumpAddr_InBus,
  input  logic [MICRO_SEQUENCER_OPFIELD-1:0] MICRO_SEQUENCER_OpField_InBus,
  input  logic                               MICRO_SEQUENCER_Call_In,
  input  logic                               MICRO_SEQUENCER_Wait_In,
  input  logic                               MICRO_SEQUENCER_Halt_In,
  output logic [MICRO_SEQUENCER_CSADDR-1:0]  MICRO_SEQUENCER_CsAddr_OutBus,
  output logic                               MICRO_SEQUENCER_Stalled_Out,
  output logic                               MICRO_SEQUENCER_Halted_Out,
  output logic                               MICRO_SEQUENCER_Error_Out
);
  localparam int AW = MICRO_SEQUENCER_CSADDR;
  localparam int DW = MICRO_SEQUENCER_OPFIELD + 3;
  state_e state, stateNext;
  tipo_e tipo;
  logic [AW-1:0] addr, addrNext, decAddr;
  logic [DW-1:0] decFull;
  logic advance, errSet, error, stalled, halted;
  assign tipo = tipo_e'(MICRO_SEQUENCER_Tipo_InBus[1:0]);
  assign decFull = {DECODE_PREFIX, MICRO_SEQUENCER_OpField_InBus, DECODE_SUFFIX};
  assign decAddr = AW'(decFull);
  // Leaving WAIT applies the Tipo on the same edge, so RUN and WAIT advance alike.
  assign advance = (state == S_RUN || state == S_WAIT) && !MICRO_SEQUENCER_Halt_In && !MICRO_SEQUENCER_Wait_In;
`ifdef MICRO_SEQUENCER_CALL_STACK_EN
  logic stkPush, stkPop, stkFull, stkEmpty;
  logic [AW-1:0] stkTop;
  assign stkPush = advance && tipo == TIPO_JUMP && MICRO_SEQUENCER_Call_In;
  assign stkPop = advance && tipo == TIPO_RETURN;
  micro_return_stack #(.WIDTH(AW), .DEPTH(MICRO_SEQUENCER_STACK_DEPTH)) uStack (
    .clk(MICRO_SEQUENCER_CLOCK_50),
    .rst_n(MICRO_SEQUENCER_ResetInLow_In),
    .push(stkPush),
    .pop(stkPop),
    .pushData(addr + 1'b1),
    .topData(stkTop),
    .full(stkFull),
    .empty(stkEmpty)
  );
`else
  logic unusedCall;
  assign unusedCall = MICRO_SEQUENCER_Call_In;
`endif
  always_comb begin
    stateNext = state == S_BOOT ? S_RUN :
                state == S_HALT ? S_HALT :
                MICRO_SEQUENCER_Halt_In ? S_HALT :
                MICRO_SEQUENCER_Wait_In ? S_WAIT : S_RUN;
    addrNext = addr;
    errSet = 1'b0;
    if (advance)
      case (tipo)
        TIPO_JUMP: begin
          addrNext = MICRO_SEQUENCER_JumpAddr_InBus;
`ifdef MICRO_SEQUENCER_CALL_STACK_EN
          errSet = stkPush && stkFull;
`endif
        end
        TIPO_DECODE: addrNext = decAddr;
`ifdef MICRO_SEQUENCER_CALL_STACK_EN
        TIPO_RETURN: begin
          addrNext = stkEmpty ? '0 : stkTop;
          errSet = stkEmpty;
        end
`endif
        default: begin
          addrNext = addr + 1'b1;
          errSet = &addr;
        end
      endcase
  end
  always_ff @(posedge MICRO_SEQUENCER_CLOCK_50 or negedge MICRO_SEQUENCER_ResetInLow_In)
    if (!MICRO_SEQUENCER_ResetInLow_In) begin
      state <= S_BOOT;
      addr <= '0;
      error <= 1'b0;
      stalled <= 1'b0;
      halted <= 1'b0;
    end else begin
      state <= stateNext;
      addr <= addrNext;
      error <= error | errSet;
      stalled <= stateNext == S_WAIT;
      halted <= stateNext == S_HALT;
    end
  assign MICRO_SEQUENCER_CsAddr_OutBus = addr;
  assign MICRO_SEQUENCER_Stalled_Out = stalled;
  assign MICRO_SEQUENCER_Halted_Out = halted;
  assign MICRO_SEQUENCER_Error_Out = error;
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: table-driven directed check of micro_sequencer
module tb_micro_sequencer;
  typedef struct {
    logic halt;
    logic wt;
    logic [1:0] tipo;
    logic [10:0] jump;
    logic [7:0] op;
    logic call;
    logic [10:0] eAddr;
    logic eSt;
    logic eHt;
    logic eErr;
  } vec_t;
  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic [1:0] tipo = 2'b00;
  logic [10:0] jumpAddr = '0;
  logic [7:0] opField = '0;
  logic call = 1'b0, waitIn = 1'b0, haltIn = 1'b0;
  logic [10:0] csAddr;
  logic stalled, halted, error;
  int compared = 0;
  int mismatched = 0;
  vec_t tbl[$];
  always #5 clk = ~clk;
  micro_sequencer dut (
    .MICRO_SEQUENCER_CLOCK_50(clk),
    .MICRO_SEQUENCER_ResetInLow_In(rstN),
    .MICRO_SEQUENCER_Tipo_InBus(tipo),
    .MICRO_SEQUENCER_JumpAddr_InBus(jumpAddr),
    .MICRO_SEQUENCER_OpField_InBus(opField),
    .MICRO_SEQUENCER_Call_In(call),
    .MICRO_SEQUENCER_Wait_In(waitIn),
    .MICRO_SEQUENCER_Halt_In(haltIn),
    .MICRO_SEQUENCER_CsAddr_OutBus(csAddr),
    .MICRO_SEQUENCER_Stalled_Out(stalled),
    .MICRO_SEQUENCER_Halted_Out(halted),
    .MICRO_SEQUENCER_Error_Out(error)
  );
  function automatic vec_t mk(input logic h, input logic w, input logic [1:0] t, input logic [10:0] j,
                              input logic [7:0] o, input logic c, input logic [10:0] ea,
                              input logic es, input logic eh, input logic ee);
    vec_t v;
    v.halt = h; v.wt = w; v.tipo = t; v.jump = j; v.op = o; v.call = c;
    v.eAddr = ea; v.eSt = es; v.eHt = eh; v.eErr = ee;
    return v;
  endfunction
  task automatic check(input string name, input logic [10:0] ea, input logic es, input logic eh, input logic ee);
    compared++;
    if ({csAddr, stalled, halted, error} !== {ea, es, eh, ee}) begin
      mismatched++;
      $display("FAIL %s: got addr=%h stalled=%b halted=%b error=%b, want addr=%h stalled=%b halted=%b error=%b",
               name, csAddr, stalled, halted, error, ea, es, eh, ee);
    end
  endtask
  task automatic apply(input vec_t v, input string name);
    haltIn = v.halt; waitIn = v.wt; tipo = v.tipo; jumpAddr = v.jump; opField = v.op; call = v.call;
    @(posedge clk);
    #1;
    check(name, v.eAddr, v.eSt, v.eHt, v.eErr);
  endtask
  task automatic pulseReset();
    @(negedge clk) rstN = 1'b0;
    @(negedge clk) rstN = 1'b1;
  endtask
  initial begin
    tbl.push_back(mk(0, 0, 2'b00, 11'h000, 8'h00, 0, 11'h000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 2'b00, 11'h000, 8'h00, 0, 11'h001, 0, 0, 0));
    tbl.push_back(mk(0, 0, 2'b00, 11'h000, 8'h00, 0, 11'h002, 0, 0, 0));
    tbl.push_back(mk(0, 0, 2'b00, 11'h000, 8'h00, 0, 11'h003, 0, 0, 0));
    tbl.push_back(mk(0, 0, 2'b10, 11'h000, 8'h80, 0, 11'h600, 0, 0, 0));
    tbl.push_back(mk(0, 0, 2'b01, 11'h123, 8'h00, 0, 11'h123, 0, 0, 0));
    tbl.push_back(mk(0, 0, 2'b01, 11'h005, 8'h00, 0, 11'h005, 0, 0, 0));
    tbl.push_back(mk(0, 1, 2'b00, 11'h000, 8'h00, 0, 11'h005, 1, 0, 0));
    tbl.push_back(mk(0, 1, 2'b00, 11'h000, 8'h00, 0, 11'h005, 1, 0, 0));
    tbl.push_back(mk(0, 0, 2'b00, 11'h000, 8'h00, 0, 11'h006, 0, 0, 0));
    tbl.push_back(mk(0, 0, 2'b10, 11'h000, 8'h3F, 0, 11'h4FC, 0, 0, 0));
    tbl.push_back(mk(0, 0, 2'b01, 11'h7FE, 8'h00, 0, 11'h7FE, 0, 0, 0));
    tbl.push_back(mk(0, 0, 2'b00, 11'h000, 8'h00, 0, 11'h7FF, 0, 0, 0));
    tbl.push_back(mk(0, 0, 2'b00, 11'h000, 8'h00, 0, 11'h000, 0, 0, 1));
    tbl.push_back(mk(0, 0, 2'b00, 11'h000, 8'h00, 0, 11'h001, 0, 0, 1));
    tbl.push_back(mk(0, 1, 2'b00, 11'h000, 8'h00, 0, 11'h001, 1, 0, 1));
    tbl.push_back(mk(0, 0, 2'b01, 11'h055, 8'h00, 0, 11'h055, 0, 0, 1));
    tbl.push_back(mk(1, 1, 2'b00, 11'h000, 8'h00, 0, 11'h055, 0, 1, 1));
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 11'h000, 0, 0, 0);
    @(negedge clk) rstN = 1'b1;
    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));
    for (int i = 0; i < 10; i++)
      apply(mk(i[0], 0, 2'(i), 11'h0AA, 8'hFF, 1, 11'h055, 0, 1, 1), "halt_hold");
    @(posedge clk);
    #2 rstN = 1'b0;
    #1 check("async_reset", 11'h000, 0, 0, 0);
    @(negedge clk) rstN = 1'b1;
`ifdef MICRO_SEQUENCER_CALL_STACK_EN
    apply(mk(0, 0, 2'b00, 11'h000, 8'h00, 0, 11'h000, 0, 0, 0), "stk_boot");
    apply(mk(0, 0, 2'b01, 11'h010, 8'h00, 0, 11'h010, 0, 0, 0), "stk_jump");
    apply(mk(0, 0, 2'b01, 11'h200, 8'h00, 1, 11'h200, 0, 0, 0), "stk_call");
    apply(mk(0, 0, 2'b11, 11'h000, 8'h00, 0, 11'h011, 0, 0, 0), "stk_ret");
    apply(mk(0, 0, 2'b11, 11'h000, 8'h00, 0, 11'h000, 0, 0, 1), "stk_pop_empty");
    pulseReset();
    apply(mk(0, 0, 2'b00, 11'h000, 8'h00, 0, 11'h000, 0, 0, 0), "nest_boot");
    for (int i = 1; i <= 5; i++)
      apply(mk(0, 0, 2'b01, 11'(i * 256), 8'h00, 1, 11'(i * 256), 0, 0, i == 5), "nest_call");
    for (int i = 3; i >= 0; i--)
      apply(mk(0, 0, 2'b11, 11'h000, 8'h00, 0, 11'(i * 256 + 1), 0, 0, 1), "nest_ret");
    apply(mk(0, 0, 2'b11, 11'h000, 8'h00, 0, 11'h000, 0, 0, 1), "nest_ret_empty");
`else
    apply(mk(0, 0, 2'b00, 11'h000, 8'h00, 0, 11'h000, 0, 0, 0), "nostk_boot");
    apply(mk(0, 0, 2'b01, 11'h010, 8'h00, 0, 11'h010, 0, 0, 0), "nostk_jump");
    apply(mk(0, 0, 2'b01, 11'h200, 8'h00, 1, 11'h200, 0, 0, 0), "nostk_call");
    apply(mk(0, 0, 2'b11, 11'h000, 8'h00, 0, 11'h201, 0, 0, 0), "nostk_ret_is_next");
    apply(mk(0, 0, 2'b11, 11'h000, 8'h00, 0, 11'h202, 0, 0, 0), "nostk_ret_again");
    for (int i = 1; i <= 5; i++)
      apply(mk(0, 0, 2'b01, 11'(i * 256), 8'h00, 1, 11'(i * 256), 0, 0, 0), "nostk_call_ignored");
    apply(mk(0, 0, 2'b11, 11'h000, 8'h00, 0, 11'h501, 0, 0, 0), "nostk_ret_next");
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
